neural_layer_engine: RTL and testbench

NEURAL_LAYER_ENGINE -- requirements
Module: neural_layer_engine

---
 rtl/neural_layer_engine.sv | 192 +++++++++++++++++++
 tb/tb_neural_layer_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neural_layer_engine.sv
// Purpose: sequential fully-connected layer engine; streams one input vector through up to LMAX layers and streams out the final layer.
// Latency: one NEXT cycle plus nk(L)*(nk(L-1)+2) cycles per computed layer, after nk(0) load beats; done one cycle after the last output beat.
// Backpressure: in_ready only in LOAD; DRAIN holds out_data stable while out_ready=0.
//
// Ports:
//   clk, reset             single clock, synchronous active-low reset
//   cfg_we/cfg_layer/cfg_nk layer-table write (ignored while busy, clamped to NMAX)
//   num_layers, start      run request, accepted from IDLE only
//   in_valid/in_data/in_ready    input-vector stream (layer 0)
//   w_addr/w_data          weight ROM {layer, neuron, input}, data one cycle after address
//   out_valid/out_data/out_ready result stream of the final layer
//   busy, done             busy outside IDLE; done pulses at end of run or abort
module neural_layer_engine #(
    parameter int DW   = 8,
    parameter int NMAX = 16,
    parameter int LMAX = 4,
    parameter int FRAC = 4,
    parameter int RELU = 1,
    localparam int AW  = $clog2(NMAX),
    localparam int LW  = $clog2(LMAX)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [LW-1:0]          cfg_layer,
    input  logic [AW:0]            cfg_nk,
    input  logic [LW:0]            num_layers,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [DW-1:0]          in_data,
    output logic                   in_ready,
    output logic [AW*2+LW-1:0]     w_addr,
    input  logic signed [DW-1:0]   w_data,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);
    localparam int ACW = 2*DW + AW;
    localparam logic [AW:0]     N_ONE = 1;
    localparam logic [LW:0]     NL_ONE = 1;
    localparam logic [LW-1:0]   L_ONE = 1;
    localparam logic signed [ACW-1:0] SMAX = ACW'((1 << (DW-1)) - 1);
    localparam logic signed [ACW-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_FLUSH, S_WRITE, S_NEXT, S_DRAIN} state_t;

    state_t state, state_nxt;

    logic [LW-1:0] l;
    logic [AW-1:0] j, i, k;
    // sel is the bank being read; the layer under construction is always mem[~sel].
    logic          sel;
    logic [LW:0]   nl_r;
    logic [AW:0]   nk_tab [LMAX];
    logic signed [DW-1:0] mem [2][NMAX];

    logic signed [DW-1:0]    act_d;
    logic                    pv, pfirst;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACW-1:0]   prod_ext, acc, sh, rl;
    logic signed [DW-1:0]    wr_val;

    logic [AW:0] nin, nout, nk_nxt;
    logic        last_i, last_j, last_k, last_l, start_ok;

    assign nin    = nk_tab[l - L_ONE];
    assign nout   = nk_tab[l];
    assign nk_nxt = nk_tab[l + L_ONE];
    assign last_i = ({1'b0, i} == nin - N_ONE);
    assign last_j = ({1'b0, j} == nout - N_ONE);
    // LOAD (l=0) and DRAIN (l=last layer) both count to nk(l).
    assign last_k = ({1'b0, k} == nout - N_ONE);
    assign last_l = ({1'b0, l} == nl_r - NL_ONE);
    assign start_ok = start && (num_layers != '0) && (num_layers <= (LW+1)'(LMAX))
                      && (nk_tab[0] != '0);

    assign prod     = act_d * w_data;
    assign prod_ext = {{AW{prod[2*DW-1]}}, prod};

    // Requantise: scale, optional ReLU on hidden layers, then saturate to DW bits.
    always_comb begin
        sh = acc >>> FRAC;
        rl = sh;
        if (RELU != 0 && !last_l && sh < 0)
            rl = '0;
        if (rl > SMAX)
            wr_val = SMAX[DW-1:0];
        else if (rl < SMIN)
            wr_val = SMIN[DW-1:0];
        else
            wr_val = rl[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_LOAD;
            S_LOAD:  if (in_valid && last_k) state_nxt = last_l ? S_DRAIN : S_NEXT;
            S_MAC:   if (last_i) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_WRITE;
            S_WRITE: if (last_j) state_nxt = last_l ? S_DRAIN : S_NEXT;
                     else        state_nxt = S_MAC;
            S_NEXT:  state_nxt = (nk_nxt == '0) ? S_IDLE : S_MAC;
            S_DRAIN: if (out_ready && last_k) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        in_ready  = (state == S_LOAD);
        out_valid = (state == S_DRAIN);
        out_data  = out_valid ? mem[~sel][k] : '0;
        w_addr    = (state == S_MAC) ? {l, j, i} : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            l      <= '0;
            j      <= '0;
            i      <= '0;
            k      <= '0;
            sel    <= 1'b0;
            nl_r   <= '0;
            acc    <= '0;
            act_d  <= '0;
            pv     <= 1'b0;
            pfirst <= 1'b0;
            done   <= 1'b0;
            for (int n = 0; n < LMAX; n++)
                nk_tab[n] <= '0;
        end else begin
            done <= 1'b0;
            // Activation is delayed to line up with the registered ROM data.
            pv     <= (state == S_MAC);
            pfirst <= (state == S_MAC) && (i == '0);
            act_d  <= mem[sel][i];
            if (pv)
                acc <= pfirst ? prod_ext : acc + prod_ext;
            if (cfg_we && state == S_IDLE)
                nk_tab[cfg_layer] <= (cfg_nk > (AW+1)'(NMAX)) ? (AW+1)'(NMAX) : cfg_nk;
            case (state)
                S_IDLE: if (start_ok) begin
                    nl_r <= num_layers;
                    l    <= '0;
                    j    <= '0;
                    i    <= '0;
                    k    <= '0;
                    // Start inverted so LOAD fills bank 0 and the first NEXT points reads at it.
                    sel  <= 1'b1;
                end
                S_LOAD: if (in_valid) k <= last_k ? '0 : k + 1'b1;
                S_MAC:  i <= last_i ? '0 : i + 1'b1;
                S_WRITE: begin
                    j <= last_j ? '0 : j + 1'b1;
                    k <= '0;
                end
                S_NEXT: begin
                    l   <= l + L_ONE;
                    sel <= ~sel;
                    if (nk_nxt == '0)
                        done <= 1'b1;
                end
                S_DRAIN: if (out_ready) begin
                    k <= k + 1'b1;
                    if (last_k)
                        done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Neuron banks carry no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == S_LOAD && in_valid)
                mem[~sel][k] <= in_data;
            else if (state == S_WRITE)
                mem[~sel][j] <= wr_val;
        end
    end
endmodule

// File: tb/tb_neural_layer_engine.sv
module tb_neural_layer_engine;
    logic              clk = 0;
    logic              reset = 0;
    logic              cfg_we = 0;
    logic [1:0]        cfg_layer = 0;
    logic [4:0]        cfg_nk = 0;
    logic [2:0]        num_layers = 0;
    logic              start = 0;
    logic              in_valid = 0;
    logic [7:0]        in_data = 0;
    logic              in_ready;
    logic [9:0]        w_addr;
    logic signed [7:0] w_data = 0;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready = 1;
    logic              busy, done;

    neural_layer_engine #(.DW(8), .NMAX(16), .LMAX(4), .FRAC(0), .RELU(1)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_nk(cfg_nk),
        .num_layers(num_layers), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Registered weight ROM indexed {layer, neuron, input}.
    logic signed [7:0] rom [1024];
    always @(posedge clk) w_data <= rom[w_addr];

    int checks = 0;
    int errors = 0;
    int tx [16];
    int rx [32];
    int rx_n;
    int stall_bad;

    task automatic cfg(input int layer, input int nk);
        cfg_we = 1; cfg_layer = layer[1:0]; cfg_nk = nk[4:0];
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic pulse_start(input int nl);
        start = 1; num_layers = nl[2:0];
        @(negedge clk);
        start = 0;
    endtask

    task automatic send_inputs(input int n, output bit ok);
        ok = 1;
        for (int b = 0; b < n; b++) begin
            in_valid = 1; in_data = tx[b][7:0];
            for (int c = 0; c < 50 && !in_ready; c++) @(negedge clk);
            if (!in_ready) begin ok = 0; break; end
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    task automatic recv_outputs(input bit toggle, output bit ok);
        bit prev_stall = 0;
        logic [7:0] prev_d = 0;
        rx_n = 0; stall_bad = 0; ok = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done) begin ok = 1; break; end
            if (prev_stall && out_data !== prev_d) stall_bad++;
            out_ready = toggle ? ~out_ready : 1'b1;
            if (out_valid && out_ready) begin
                if (rx_n < 32) rx[rx_n] = $signed(out_data);
                rx_n++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            @(negedge clk);
        end
        out_ready = 1;
    endtask

    task automatic test_reset;
        reset = 0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (w_addr !== 10'h000) begin errors++; $display("FAIL reset_w_addr got %h want 000", w_addr); end
        reset = 1;
        @(negedge clk);
        // Layer table is zero after reset, so a start must be ignored.
        pulse_start(1);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_table_start busy got %b want 0", busy); end
    endtask

    task automatic test_passthrough;
        bit ok;
        int exp_v [3] = '{5, -2, 7};
        cfg(0, 3);
        tx[0] = 5; tx[1] = -2; tx[2] = 7;
        pulse_start(1);
        send_inputs(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pass_load_timeout got 0 want 1"); end
        recv_outputs(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pass_done_timeout got 0 want 1"); end
        checks++; if (rx_n !== 3) begin errors++; $display("FAIL pass_count got %0d want 3", rx_n); end
        for (int b = 0; b < 3; b++) begin
            checks++; if (rx[b] !== exp_v[b]) begin errors++; $display("FAIL pass_data[%0d] got %0d want %0d", b, rx[b], exp_v[b]); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pass_done_pulse got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy_end got %b want 0", busy); end
    endtask

    task automatic run_two_layer(input string tag, input bit chk_lat);
        bit ok;
        int c;
        cfg(0, 2); cfg(1, 2);
        rom[256] = 1; rom[257] = 1; rom[272] = 1; rom[273] = 1;
        tx[0] = 3; tx[1] = 4;
        pulse_start(2);
        send_inputs(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_load_timeout got 0 want 1", tag); end
        // One NEXT cycle, then 2 neurons * (2 MAC + FLUSH + WRITE) = 8.
        for (c = 0; c < 100 && !out_valid; c++) @(negedge clk);
        if (chk_lat) begin
            checks++; if (c !== 9) begin errors++; $display("FAIL %s_latency got %0d want 9", tag, c); end
        end
        recv_outputs(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_done_timeout got 0 want 1", tag); end
        checks++; if (rx_n !== 2) begin errors++; $display("FAIL %s_count got %0d want 2", tag, rx_n); end
        for (int b = 0; b < 2; b++) begin
            checks++; if (rx[b] !== 7) begin errors++; $display("FAIL %s_data[%0d] got %0d want 7", tag, b, rx[b]); end
        end
    endtask

    task automatic test_two_layer;
        run_two_layer("two", 1);
    endtask

    task automatic test_sat_relu;
        bit ok;
        int exp_v [2] = '{-128, 127};
        cfg(0, 2); cfg(1, 3); cfg(2, 2);
        // Hidden: -20 -> 0 (ReLU), 300 -> 127 (sat), 54.
        rom[256] = -2; rom[257] = 0;
        rom[272] = 30; rom[273] = 0;
        rom[288] = 5;  rom[289] = 1;
        // Final: 0*0 + 127*-2 + 54*1 = -200 -> -128; 0 + 127 + 0 = 127.
        rom[512] = 0; rom[513] = -2; rom[514] = 1;
        rom[528] = 1; rom[529] = 1;  rom[530] = 0;
        tx[0] = 10; tx[1] = 4;
        pulse_start(3);
        send_inputs(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_load_timeout got 0 want 1"); end
        recv_outputs(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_done_timeout got 0 want 1"); end
        checks++; if (rx_n !== 2) begin errors++; $display("FAIL sat_count got %0d want 2", rx_n); end
        for (int b = 0; b < 2; b++) begin
            checks++; if (rx[b] !== exp_v[b]) begin errors++; $display("FAIL sat_data[%0d] got %0d want %0d", b, rx[b], exp_v[b]); end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int exp_v [4] = '{11, -22, 33, -44};
        cfg(0, 4);
        for (int b = 0; b < 4; b++) tx[b] = exp_v[b];
        pulse_start(1);
        send_inputs(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_load_timeout got 0 want 1"); end
        recv_outputs(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got 0 want 1"); end
        checks++; if (rx_n !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", rx_n); end
        for (int b = 0; b < 4; b++) begin
            checks++; if (rx[b] !== exp_v[b]) begin errors++; $display("FAIL bp_data[%0d] got %0d want %0d", b, rx[b], exp_v[b]); end
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_bad); end
    endtask

    task automatic test_reset_mid_mac;
        bit ok;
        int c;
        cfg(0, 2); cfg(1, 2);
        tx[0] = 3; tx[1] = 4;
        pulse_start(2);
        send_inputs(2, ok);
        for (c = 0; c < 50 && w_addr == 0; c++) @(negedge clk);
        checks++; if (w_addr === 10'h000) begin errors++; $display("FAIL rst_reach_mac got %h want nonzero", w_addr); end
        reset = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (w_addr !== 10'h000) begin errors++; $display("FAIL rst_w_addr got %h want 000", w_addr); end
        reset = 1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_restart got %b want 0", busy); end
        run_two_layer("rst2", 0);
    endtask

    task automatic test_illegal_start;
        bit ok;
        cfg(0, 2);
        pulse_start(0);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ill_nl0 got busy=%b in_ready=%b want 0 0", busy, in_ready); end
        pulse_start(5);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ill_nl5 got busy=%b in_ready=%b want 0 0", busy, in_ready); end
        pulse_start(1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_load got %b want 1", in_ready); end
        // Restart and table write while busy must both be ignored.
        pulse_start(1);
        cfg(0, 5);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ill_busy_start got in_ready=%b busy=%b want 1 1", in_ready, busy); end
        tx[0] = 9; tx[1] = -9;
        send_inputs(2, ok);
        recv_outputs(0, ok);
        checks++; if (!ok || rx_n !== 2) begin errors++; $display("FAIL ill_busy_cfg got done=%b count=%0d want 1 2", ok, rx_n); end
        checks++; if (rx[0] !== 9 || rx[1] !== -9) begin errors++; $display("FAIL ill_data got %0d,%0d want 9,-9", rx[0], rx[1]); end
    endtask

    task automatic test_abort;
        bit ok;
        bit saw_valid = 0;
        bit saw_done = 0;
        cfg(0, 2); cfg(1, 0);
        tx[0] = 1; tx[1] = 2;
        pulse_start(2);
        send_inputs(2, ok);
        for (int c = 0; c < 20; c++) begin
            if (out_valid) saw_valid = 1;
            if (done) begin saw_done = 1; break; end
            @(negedge clk);
        end
        checks++; if (!saw_done) begin errors++; $display("FAIL abort_done got 0 want 1"); end
        checks++; if (saw_valid) begin errors++; $display("FAIL abort_out_valid got 1 want 0"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    endtask

    task automatic test_clamp;
        bit ok;
        cfg(0, 31);
        for (int b = 0; b < 16; b++) tx[b] = b * 3 - 20;
        pulse_start(1);
        send_inputs(16, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_load_timeout got 0 want 1"); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clamp_in_ready got %b want 0", in_ready); end
        recv_outputs(0, ok);
        checks++; if (!ok || rx_n !== 16) begin errors++; $display("FAIL clamp_count got done=%b count=%0d want 1 16", ok, rx_n); end
        for (int b = 0; b < 16; b++) begin
            checks++; if (rx[b] !== b * 3 - 20) begin errors++; $display("FAIL clamp_data[%0d] got %0d want %0d", b, rx[b], b * 3 - 20); end
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = 0;
        @(negedge clk);
        test_reset();
        test_passthrough();
        test_two_layer();
        test_sat_relu();
        test_backpressure();
        test_reset_mid_mac();
        test_illegal_start();
        test_abort();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
